conv_enc_k7: RTL and testbench
==============================

# conv_enc_k7

Rate-1/2, constraint-length-7 convolutional encoder with generators G0 = 171 (octal) and G1 = 133 (octal). It is the transmit-side counterpart of the 64-state Viterbi decoder. The block takes a stream of information bits over a valid/ready handshake. It emits one 2-bit code pair per bit, in the bit order the branch-metric units expect on `rx_pair`, and terminates each frame with six zero tail bits so the decoder ends in state 0.

## Interface
- `FRAME_LEN`, default 256: maximum information bits per frame. The tail starts after `in_last` or after `FRAME_LEN` accepted bits, whichever comes first. Legal range 1..65535.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_bit` is valid.
- `in_ready` output 1: encoder accepts `in_bit` this cycle.
- `in_bit` input 1: information bit u[n].
- `in_last` input 1: qualifies the final information bit of the frame.
- `out_valid` output 1: `out_pair` is valid.
- `out_ready` input 1: downstream consumes `out_pair` this cycle.
- `out_pair` output 2: [1] = G0 parity, [0] = G1 parity (same bit order as `rx_pair` at the decoder).
- `out_last` output 1: marks the final tail pair of a frame.
- `busy` output 1: high while a frame is in progress (DATA with at least one bit accepted, or TAIL).

## Operation
- State register `sr[5:0]` holds past inputs: `sr[0]` = u[n-1] … `sr[5]` = u[n-6].
- Parity for current input u:
  - G0 = u ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5]
  - G1 = u ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5]
- On each encode step, `sr` is updated to {sr[4:0], u}.
- FSM states:
  - DATA: `in_ready` = !out_valid | out_ready. On an accept (in_valid & in_ready):
    - encode `in_bit`;
    - load `out_pair`;
    - set `out_valid`;
    - increment `bit_cnt`.
    - If `in_last`, or `bit_cnt` reaches FRAME_LEN-1 before the increment, go to TAIL with `tail_cnt` = 0.
  - TAIL: `in_ready` = 0. Whenever the output register is free (!out_valid | out_ready), encode u = 0 and increment `tail_cnt`. On the 6th tail pair, set `out_last` = 1, clear `bit_cnt`, and return to DATA.
- After the tail, `sr` is all zeros by construction. No explicit clear is needed, but one is permitted.
- Output register: `out_pair`, `out_valid` and `out_last` hold stable while out_valid & !out_ready.
- `out_last` is cleared when its pair is consumed.
- Back-to-back frames: the first bit of the next frame may be accepted in the same cycle the `out_last` pair is consumed.
- `in_last` is ignored when `in_valid` is low. Input bits are never dropped or duplicated.

## Timing
- Reset values: `out_valid` = 0, `out_pair` = 2'b00, `out_last` = 0, `busy` = 0, `sr` = 0, FSM = DATA, counters = 0. `in_ready` = 1 immediately after reset.
- Latency: the pair for a bit accepted at edge k is valid after edge k.
- Throughput: one pair per cycle when `out_ready` is held high, including across the DATA→TAIL transition with no bubble.
- A frame of N bits produces exactly N+6 pairs.
- `rst` asserted mid-frame:
  - all state clears asynchronously;
  - the partial frame is discarded with no tail;
  - `out_valid` drops in the same cycle.
- Simultaneous `in_last` and FRAME_LEN limit: treated as a single frame end, with one tail.

## Test plan
- Impulse: one bit 1 with `in_last`, `out_ready` = 1 → pairs 11, 10, 11, 11, 00, 01, 11. `out_last` is on the 7th pair only. `busy` drops afterwards.
- All-zero frame of 10 bits → 16 pairs, all 00. `out_last` is on the 16th pair.
- Backpressure: impulse frame with `out_ready` toggled pseudo-randomly → identical pair sequence. `out_pair` is stable while stalled, and `in_ready` = 0 during stalls with a full output register.
- FRAME_LEN = 4, stream of 9 ones with no `in_last` → frame 1 is 4 bits + 6 tail. Frame 2 then starts from state 0 with the remaining bits. Pairs match the golden model, and there is exactly one `out_last` per frame.
- Reset mid-frame: assert `rst` after 3 accepted bits → outputs return to reset values at once. A new impulse frame then reproduces 11, 10, 11, 11, 00, 01, 11.
- Loopback: 256 random bits → decoder output equals the input bits with zero errors.

Source files
------------

// File: rtl/conv_enc_k7.sv
// Rate-1/2, K=7 convolutional encoder (G0 = 171 octal, G1 = 133 octal).
// Information bits arrive on a valid/ready handshake, and each bit produces one
// 2-bit code pair. After in_last, or after FRAME_LEN bits, six zero tail bits
// flush the shift register so the decoder finishes in state 0.
module conv_enc_k7 #(
    parameter int FRAME_LEN = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_pair,
    output logic       out_last,
    output logic       busy
);

    localparam logic [0:0]  ST_DATA   = 1'b0;
    localparam logic [0:0]  ST_TAIL   = 1'b1;
    localparam logic [15:0] LAST_IDX  = 16'(FRAME_LEN - 1);
    localparam logic [2:0]  TAIL_LAST = 3'd5;

    logic [0:0]  state_q,    state_d;
    logic [5:0]  sr_q,       sr_d;
    logic [15:0] bit_cnt_q,  bit_cnt_d;
    logic [2:0]  tail_cnt_q, tail_cnt_d;
    logic [1:0]  out_pair_q, out_pair_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q,  out_last_d;

    logic out_free;
    logic accept;
    logic tail_step;
    logic enc_step;
    logic enc_u;
    logic par_g0;
    logic par_g1;

    // Handshake qualifiers and parity of the bit being encoded this cycle.
    // The output register counts as free when it is empty or when it is being
    // drained this cycle. This allows one pair per cycle with no bubble.
    always_comb begin
        out_free  = !out_valid_q || out_ready;
        accept    = (state_q == ST_DATA) && out_free && in_valid;
        tail_step = (state_q == ST_TAIL) && out_free;
        enc_step  = accept || tail_step;
        enc_u     = accept ? in_bit : 1'b0;
        par_g0    = enc_u ^ sr_q[0] ^ sr_q[1] ^ sr_q[2] ^ sr_q[5];
        par_g1    = enc_u ^ sr_q[1] ^ sr_q[2] ^ sr_q[4] ^ sr_q[5];
    end

    // Next-state logic for the FSM, the shift register, the counters and the
    // output register.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        out_pair_d  = out_pair_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        // A consumed pair empties the register. out_pair keeps its last value.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        // Any encode step, data or tail, shifts u in and reloads the output.
        if (enc_step) begin
            sr_d        = {sr_q[4:0], enc_u};
            out_pair_d  = {par_g0, par_g1};
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
        end

        // in_last and the length limit may coincide. Both lead to one tail.
        if (accept) begin
            bit_cnt_d = bit_cnt_q + 16'd1;
            if (in_last || (bit_cnt_q == LAST_IDX)) begin
                state_d    = ST_TAIL;
                tail_cnt_d = 3'd0;
            end
        end

        // The sixth tail pair closes the frame. sr is all zeros at that point.
        if (tail_step) begin
            if (tail_cnt_q == TAIL_LAST) begin
                out_last_d = 1'b1;
                bit_cnt_d  = 16'd0;
                tail_cnt_d = 3'd0;
                state_d    = ST_DATA;
            end else begin
                tail_cnt_d = tail_cnt_q + 3'd1;
            end
        end
    end

    // State registers with asynchronous clear. A reset mid-frame drops the
    // partial frame with no tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_DATA;
            sr_q        <= 6'd0;
            bit_cnt_q   <= 16'd0;
            tail_cnt_q  <= 3'd0;
            out_pair_q  <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            out_pair_q  <= out_pair_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Output drive. busy is high from the first accepted bit to the end of the tail.
    always_comb begin
        in_ready  = (state_q == ST_DATA) && out_free;
        out_valid = out_valid_q;
        out_pair  = out_pair_q;
        out_last  = out_last_q;
        busy      = (state_q == ST_TAIL) || (bit_cnt_q != 16'd0);
    end

endmodule

// File: tb/tb_conv_enc_k7.sv
// Directed, table-driven bench for conv_enc_k7. It uses one instance with the
// default FRAME_LEN and one with FRAME_LEN = 4, which share a single stimulus
// and observation path chosen by sel.
module tb_conv_enc_k7;

    typedef struct {
        logic       has_in;
        logic       in_bit;
        logic       in_last;
        logic [1:0] exp_pair;
        logic       exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b1;
    logic sel = 1'b0;

    logic       in_ready_a, out_valid_a, out_last_a, busy_a;
    logic [1:0] out_pair_a;
    logic       in_ready_b, out_valid_b, out_last_b, busy_b;
    logic [1:0] out_pair_b;

    logic       o_in_ready, o_out_valid, o_out_last, o_busy;
    logic [1:0] o_out_pair;
    logic       in_valid_a, in_valid_b;

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    logic [1:0] got_pair[$];
    logic       got_last[$];
    logic       prev_stall = 1'b0;
    logic [1:0] prev_pair = 2'b00;
    logic       rand_ready = 1'b0;
    logic [6:0] g0_poly = 7'o171;
    logic [6:0] g1_poly = 7'o133;
    logic       ubits[0:127];

    always #5 clk = ~clk;

    assign in_valid_a  = in_valid & ~sel;
    assign in_valid_b  = in_valid & sel;
    assign o_in_ready  = sel ? in_ready_b  : in_ready_a;
    assign o_out_valid = sel ? out_valid_b : out_valid_a;
    assign o_out_last  = sel ? out_last_b  : out_last_a;
    assign o_out_pair  = sel ? out_pair_b  : out_pair_a;
    assign o_busy      = sel ? busy_b      : busy_a;

    conv_enc_k7 #(.FRAME_LEN(256)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_pair(out_pair_a), .out_last(out_last_a),
        .busy(busy_a)
    );

    conv_enc_k7 #(.FRAME_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_pair(out_pair_b), .out_last(out_last_b),
        .busy(busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic h, input logic b, input logic l,
                       input logic [1:0] p, input logic el);
        vec_t v;
        v.has_in = h; v.in_bit = b; v.in_last = l; v.exp_pair = p; v.exp_last = el;
        tbl.push_back(v);
    endtask

    // One clock. Observe at the falling edge, then drive just after the rising edge.
    task automatic cycle(output logic acc);
        @(negedge clk);
        acc = in_valid && o_in_ready;
        if (o_out_valid && out_ready) begin
            got_pair.push_back(o_out_pair);
            got_last.push_back(o_out_last);
        end
        if (o_out_valid && !out_ready)
            chk("stall_in_ready", {31'd0, o_in_ready}, 32'd0);
        if (prev_stall)
            chk("stall_hold", {29'd0, o_out_valid, o_out_pair}, {29'd1, prev_pair});
        prev_stall = o_out_valid && !out_ready;
        prev_pair  = o_out_pair;
        @(posedge clk);
        #1;
    endtask

    task automatic pick_ready();
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Send the inputs in tbl, collect every pair, and compare them with the table.
    task automatic run_table(input string nm);
        logic acc;
        int   guard;
        int   n;
        got_pair.delete();
        got_last.delete();
        foreach (tbl[i]) begin
            if (tbl[i].has_in) begin
                in_valid = 1'b1;
                in_bit   = tbl[i].in_bit;
                in_last  = tbl[i].in_last;
                guard    = 0;
                do begin
                    pick_ready();
                    cycle(acc);
                    guard++;
                end while (!acc && guard < 200);
                if (!acc) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = tbl.size();
        guard = 0;
        while (got_pair.size() < n && guard < 400) begin
            pick_ready();
            cycle(acc);
            guard++;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) cycle(acc);
        chk({nm, "_pair_count"}, got_pair.size(), n);
        for (int i = 0; i < n && i < got_pair.size(); i++) begin
            chk($sformatf("%s_pair[%0d]", nm, i), {30'd0, got_pair[i]}, {30'd0, tbl[i].exp_pair});
            chk($sformatf("%s_last[%0d]", nm, i), {31'd0, got_last[i]}, {31'd0, tbl[i].exp_last});
        end
        $display("%s: %0d pairs collected, %0d expected", nm, got_pair.size(), n);
    endtask

    task automatic load_impulse();
        tbl.delete();
        add(1, 1, 1, 2'b11, 0);
        add(0, 0, 0, 2'b10, 0);
        add(0, 0, 0, 2'b11, 0);
        add(0, 0, 0, 2'b11, 0);
        add(0, 0, 0, 2'b00, 0);
        add(0, 0, 0, 2'b01, 0);
        add(0, 0, 0, 2'b11, 1);
    endtask

    // Reference encoder: generator polynomials applied to the input history.
    task automatic load_random(input int n);
        logic g0, g1, u;
        tbl.delete();
        for (int k = 0; k < n; k++) ubits[k] = 1'($urandom_range(0, 1));
        for (int k = n; k < n + 6; k++) ubits[k] = 1'b0;
        for (int k = 0; k < n + 6; k++) begin
            g0 = 1'b0;
            g1 = 1'b0;
            for (int d = 0; d <= 6; d++) begin
                if (k - d >= 0) begin
                    u = ubits[k - d];
                    if (g0_poly[6 - d]) g0 ^= u;
                    if (g1_poly[6 - d]) g1 ^= u;
                end
            end
            add(k < n, ubits[k], k == n - 1, {g0, g1}, k == n + 5);
        end
    endtask

    logic [1:0] ones4[0:9];

    initial begin
        logic acc;
        ones4 = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
        chk("rst_out_pair",  {30'd0, o_out_pair},  32'd0);
        chk("rst_out_last",  {31'd0, o_out_last},  32'd0);
        chk("rst_busy",      {31'd0, o_busy},      32'd0);
        chk("rst_in_ready",  {31'd0, o_in_ready},  32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Impulse with out_ready held high.
        load_impulse();
        run_table("impulse");
        chk("impulse_busy_after", {31'd0, o_busy}, 32'd0);

        // All-zero frame of 10 bits.
        tbl.delete();
        for (int i = 0; i < 10; i++) add(1, 0, i == 9, 2'b00, 0);
        for (int i = 0; i < 6; i++)  add(0, 0, 0, 2'b00, i == 5);
        run_table("zeros10");

        // Impulse under pseudo-random backpressure.
        rand_ready = 1'b1;
        load_impulse();
        run_table("impulse_bp");
        rand_ready = 1'b0;

        // Reset after three accepted bits.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            in_last  = 1'b0;
            cycle(acc);
        end
        in_valid = 1'b0;
        chk("mid_busy_before", {31'd0, o_busy}, 32'd1);
        chk("mid_valid_before", {31'd0, o_out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, o_out_valid}, 32'd0);
        chk("mid_rst_out_pair",  {30'd0, o_out_pair},  32'd0);
        chk("mid_rst_busy",      {31'd0, o_busy},      32'd0);
        chk("mid_rst_in_ready",  {31'd0, o_in_ready},  32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_stall = 1'b0;
        load_impulse();
        run_table("impulse_after_rst");

        // Random frame with backpressure, checked against the reference encoder.
        rand_ready = 1'b1;
        load_random(40);
        run_table("random40");
        rand_ready = 1'b0;

        // FRAME_LEN = 4 with nine ones and no in_last: two full frames, and the
        // third frame still open.
        sel = 1'b1;
        prev_stall = 1'b0;
        tbl.delete();
        for (int f = 0; f < 2; f++)
            for (int j = 0; j < 10; j++) add(j < 4, 1, 0, ones4[j], j == 9);
        add(1, 1, 0, 2'b11, 0);
        run_table("flen4");
        chk("flen4_busy_open", {31'd0, o_busy}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
